// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths, side encoding and FSM states for the I2S frame packer
package i2s_pkg;
  localparam int SEQ_W = 8;
  localparam int CHAN_W = 3;
  localparam int DROP_W = 16;
  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;
  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; dout presents the head entry, zero when empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/i2s_frame_packer.sv
// i2s_frame_packer: snapshots N_PORTS stereo I2S words at every WCLK edge and streams the
// enabled channels as tagged, sequence-numbered words through a show-ahead FIFO
module i2s_frame_packer
  import i2s_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int WIDTH = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     USBCLK_IN,
  input  logic                     RST_IN,
  input  logic                     WCLK_IN,
  input  logic [N_PORTS*WIDTH-1:0] DATA_L_IN,
  input  logic [N_PORTS*WIDTH-1:0] DATA_R_IN,
  input  logic [N_PORTS-1:0]       CHAN_EN,
  output logic [WIDTH-1:0]         OUT_DATA,
  output logic [SEQ_W-1:0]         OUT_ID,
  output logic [CHAN_W-1:0]        OUT_CHAN,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     OVERFLOW,
  output logic [DROP_W-1:0]        DROP_COUNT
);
  localparam int EW = WIDTH + SEQ_W + CHAN_W;
  state_t state, state_nx;
  logic s1, s2, s3;
  logic [1:0] guard;
  logic wedge, busy, last;
  logic [WIDTH-1:0] snap [N_PORTS];
  logic [N_PORTS-1:0] snap_en;
  logic side;
  logic [1:0] p;
  logic [SEQ_W-1:0] seq;
  logic en_p, push, adv, full, empty;
  logic [EW-1:0] head;
  // either WCLK transition counts, but only once the power-up guard has expired
  assign wedge = (s2 ^ s3) & (guard == 2'd3);
  assign busy = state != IDLE;
  assign last = p == 2'(N_PORTS - 1);
  always_comb begin
    en_p = snap_en[p];
    push = (state == EMIT) & en_p & ~full;
    adv = (state == EMIT) & ~(en_p & full);
    state_nx = (state == IDLE) ? (wedge ? CAPTURE : IDLE) :
               (state == CAPTURE) ? EMIT :
               (adv & last) ? IDLE : EMIT;
  end
  always_ff @(posedge USBCLK_IN or posedge RST_IN)
    if (RST_IN) begin
      {s3, s2, s1} <= '0;
      guard <= '0;
      state <= IDLE;
      p <= '0;
      seq <= '0;
      OVERFLOW <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      {s3, s2, s1} <= {s2, s1, WCLK_IN};
      guard <= guard + 2'(guard != 2'd3);
      state <= state_nx;
      p <= (state == CAPTURE) ? 2'd0 : p + 2'(adv);
      seq <= seq + SEQ_W'(push);
      OVERFLOW <= wedge & busy;
      DROP_COUNT <= DROP_COUNT + DROP_W'(wedge & busy & (DROP_COUNT != '1));
    end
  // s3 high on an edge means WCLK fell, i.e. the right-channel half-frame
  always_ff @(posedge USBCLK_IN)
    if (!busy && wedge) begin
      side <= s3 ? SIDE_R : SIDE_L;
      snap_en <= CHAN_EN;
      for (int i = 0; i < N_PORTS; i++)
        snap[i] <= s3 ? DATA_R_IN[i*WIDTH +: WIDTH] : DATA_L_IN[i*WIDTH +: WIDTH];
    end
  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(USBCLK_IN),
    .rst(RST_IN),
    .push(push),
    .din({snap[p], seq, p, side}),
    .pop(OUT_READY),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign {OUT_DATA, OUT_ID, OUT_CHAN} = head;
  assign OUT_VALID = ~empty;
endmodule

// File: tb/tb_i2s_frame_packer.sv
// tb_i2s_frame_packer: table vectors, hand-built corner sequences and a randomized
// scoreboard run against a per-half-frame transaction model
module tb_i2s_frame_packer;
  localparam int NP = 4;
  localparam int W = 24;
  localparam logic [95:0] DL = {24'h333333, 24'h222222, 24'h111111, 24'h123456};
  localparam logic [95:0] DR = {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};
  logic clk = 1'b0;
  logic rst, wclk, rdy;
  logic [95:0] dl, dr;
  logic [3:0] en;
  logic [23:0] out_data;
  logic [7:0] out_id;
  logic [2:0] out_chan;
  logic out_valid, ovf;
  logic [15:0] drop;
  int n_chk = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int ovf_cnt = 0;
  bit mon_en = 0;
  logic [7:0] exp_seq;
  logic [34:0] sb[$];
  logic [34:0] exp_w;
  typedef struct {
    logic [3:0] en;
    logic side;
    int n;
    logic [7:0] id0;
    logic [2:0] ch0;
    logic [23:0] d0;
  } vec_t;
  vec_t tbl[6];

  i2s_frame_packer #(.N_PORTS(NP), .WIDTH(W), .FIFO_DEPTH(16)) dut (
    .USBCLK_IN(clk),
    .RST_IN(rst),
    .WCLK_IN(wclk),
    .DATA_L_IN(dl),
    .DATA_R_IN(dr),
    .CHAN_EN(en),
    .OUT_DATA(out_data),
    .OUT_ID(out_id),
    .OUT_CHAN(out_chan),
    .OUT_VALID(out_valid),
    .OUT_READY(rdy),
    .OVERFLOW(ovf),
    .DROP_COUNT(drop)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    valid_cnt <= valid_cnt + int'(out_valid);
    ovf_cnt <= ovf_cnt + int'(ovf);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // one cycle; while the monitor is on, randomly accept and score popped words
  task automatic cyc();
    @(negedge clk);
    if (mon_en) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (out_valid && rdy) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rand_pop: word %h with nothing expected", {out_data, out_id, out_chan});
        end else begin
          exp_w = sb.pop_front();
          chk("rand_pop", {out_data, out_id, out_chan}, exp_w);
        end
      end
    end
  endtask

  task automatic push_model(input logic side);
    for (int p = 0; p < NP; p++)
      if (en[p]) begin
        sb.push_back({side ? dr[p*W +: W] : dl[p*W +: W], exp_seq, 2'(p), side});
        exp_seq++;
      end
  endtask

  task automatic get_word(output logic [34:0] w, output bit ok);
    ok = 0;
    w = '0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) begin
        w = {out_data, out_id, out_chan};
        ok = 1;
        rdy = 1;
        @(posedge clk);
        #1 rdy = 0;
      end
    end
  endtask

  task automatic do_reset(input logic w);
    @(negedge clk);
    rst = 1;
    wclk = w;
    rdy = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    exp_seq = 0;
    sb.delete();
  endtask

  initial begin
    logic [34:0] w, first;
    bit ok;
    int n, v, o;
    tbl[0] = '{4'hF, 1'b1, 4, 8'd1, 3'b001, 24'hAAAAAA};
    tbl[1] = '{4'hA, 1'b0, 2, 8'd5, 3'b010, 24'h111111};
    tbl[2] = '{4'h0, 1'b1, 0, 8'd7, 3'b000, 24'h000000};
    tbl[3] = '{4'h8, 1'b0, 1, 8'd7, 3'b110, 24'h333333};
    tbl[4] = '{4'h6, 1'b1, 2, 8'd8, 3'b011, 24'hBBBBBB};
    tbl[5] = '{4'hF, 1'b0, 4, 8'd10, 3'b000, 24'h123456};
    rst = 1;
    wclk = 0;
    rdy = 0;
    en = 0;
    dl = DL;
    dr = DR;
    exp_seq = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_data, out_id, out_chan, out_valid, ovf, drop}, 0);
    rst = 0;
    repeat (8) @(negedge clk);

    // single port, latency from toggle: two sync flops, capture, emit, then valid
    en = 4'b0001;
    wclk = 1;
    repeat (4) @(negedge clk);
    chk("valid_before_n3", out_valid, 0);
    @(negedge clk);
    chk("valid_at_n3", out_valid, 1);
    chk("single_word", {out_data, out_id, out_chan}, {24'h123456, 8'd0, 3'b000});
    get_word(w, ok);
    chk("single_pop", ok, 1);
    get_word(w, ok);
    chk("single_only_one", ok, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      en = tbl[i].en;
      wclk = ~tbl[i].side;
      n = 0;
      ok = 1;
      first = '0;
      for (int j = 0; j < 4 && ok; j++) begin
        get_word(w, ok);
        if (ok) begin
          if (j == 0) first = w;
          n++;
        end
      end
      chk($sformatf("tbl%0d_count", i), n, tbl[i].n);
      if (tbl[i].n > 0)
        chk($sformatf("tbl%0d_first", i), first, {tbl[i].d0, tbl[i].id0, tbl[i].ch0});
    end

    // zero enables consume no IDs and never overrun
    en = 0;
    v = valid_cnt;
    o = ovf_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wclk = ~wclk;
      repeat (24) @(negedge clk);
    end
    chk("zero_en_valid", valid_cnt - v, 0);
    chk("zero_en_ovf", ovf_cnt - o, 0);
    en = 4'b0001;
    @(negedge clk);
    wclk = ~wclk;
    get_word(w, ok);
    chk("zero_en_next", {ok, w}, {1'b1, 24'hAAAAAA, 8'd14, 3'b001});

    // backpressure: four half-frames fill the FIFO, the fifth stalls, two more overrun
    do_reset(0);
    en = 4'hF;
    o = ovf_cnt;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      wclk = ~wclk;
      if (k < 5) push_model(~wclk);
      repeat (24) @(negedge clk);
    end
    chk("bp_drop", drop, 2);
    chk("bp_ovf_pulses", ovf_cnt - o, 2);
    for (int k = 0; k < 20; k++) begin
      get_word(w, ok);
      exp_w = (sb.size() > 0) ? sb.pop_front() : '0;
      chk($sformatf("bp_word%0d", k), {ok, w}, {1'b1, exp_w});
    end
    get_word(w, ok);
    chk("bp_no_extra", ok, 0);

    // asynchronous reset in the middle of an emitted half-frame
    @(negedge clk);
    wclk = ~wclk;
    repeat (6) @(negedge clk);
    chk("mid_valid_pre", {out_valid, drop}, {1'b1, 16'd2});
    rst = 1;
    #1;
    chk("mid_reset_clear", {out_valid, drop}, 0);
    @(negedge clk);
    chk("mid_reset_next", {out_valid, drop}, 0);
    rst = 0;
    repeat (8) @(negedge clk);
    wclk = ~wclk;
    get_word(w, ok);
    chk("mid_after_id0", {ok, w}, {1'b1, 24'h123456, 8'd0, 3'b000});

    // WCLK already high at release must not look like an edge
    do_reset(1);
    v = valid_cnt;
    repeat (30) @(negedge clk);
    chk("guard_no_words", valid_cnt - v, 0);

    // randomized run: 130 half-frames on ports 0/2 (seq wraps), then random enables
    do_reset(0);
    o = ovf_cnt;
    mon_en = 1;
    for (int k = 0; k < 260; k++) begin
      cyc();
      en = (k < 130) ? 4'b0101 : 4'($urandom_range(0, 15));
      dl = {$urandom(), $urandom(), $urandom()};
      dr = {$urandom(), $urandom(), $urandom()};
      repeat (4) cyc();
      wclk = ~wclk;
      push_model(~wclk);
      repeat (20) cyc();
    end
    for (int i = 0; i < 400 && sb.size() > 0; i++) cyc();
    mon_en = 0;
    rdy = 0;
    chk("rand_drained", sb.size(), 0);
    chk("rand_no_ovf", ovf_cnt - o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
